apb_completer_arbiter: RTL and testbench

Per-completer arbiter for the APB crossbar NoC. One instance sits in front of each completer port and shares that completer among the requesters (default 3) whose address upper nibble decodes to it. It grants one requester at a time with round-robin fairness and holds the grant for the whole APB SETUP/ACCESS transfer. It generates the completer-side psel/penable and the per-requester pready/pslverr gating. A wait-state timeout aborts hung transfers with an error response.

---
 rtl/apb_xbar_pkg.sv | 25 ++
 rtl/apb_rr_picker.sv | 44 ++++
 rtl/apb_completer_arbiter.sv | 146 ++++++++++++++
 tb/tb_apb_completer_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_xbar_pkg.sv
// Shared types and constants for the APB crossbar: arbiter state encoding,
// default fabric dimensions and an index-width helper.
package apb_xbar_pkg;

    // Arbiter transfer phase
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

    // Default fabric dimensions
    localparam int NUM_REQR_DEF = 3;
    localparam int NUM_COMP_DEF = 4;

    // The completer is selected by the upper address nibble
    localparam int COMP_ID_MSB = 31;
    localparam int COMP_ID_LSB = 28;

    // Width needed to index n items; never less than one bit
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin pick: the first set request bit searching
// upward from last_id+1, wrapping modulo N.
module apb_rr_picker #(
    parameter int N    = 3,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] last_id_i,
    output logic [N-1:0]    pick_onehot_o,
    output logic [ID_W-1:0] pick_id_o,
    output logic            pick_valid_o
);

    // Candidate index for search slot gi is (last_id + gi + 1) mod N.
    // One extra bit holds the sum before the wrap; last_id < N so a
    // single subtraction is enough.
    logic [ID_W-1:0] cand_id [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [ID_W:0] sum;
            assign sum = {1'b0, last_id_i} + (ID_W+1)'(gi + 1);
            assign cand_id[gi] = (sum >= (ID_W+1)'(N))
                               ? ID_W'(sum - (ID_W+1)'(N))
                               : sum[ID_W-1:0];
        end
    endgenerate

    // Walk the slots from farthest to nearest so the nearest hit wins
    always_comb begin
        pick_onehot_o = '0;
        pick_id_o     = '0;
        pick_valid_o  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[cand_id[i]]) begin
                pick_onehot_o              = '0;
                pick_onehot_o[cand_id[i]]  = 1'b1;
                pick_id_o                  = cand_id[i];
                pick_valid_o               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_completer_arbiter.sv
// Per-completer APB arbiter: round-robin grant among requesters, holds the
// grant across SETUP/ACCESS, drives completer psel/penable, routes
// pready/pslverr back to the granted requester, aborts hung transfers.
module apb_completer_arbiter
    import apb_xbar_pkg::*;
#(
    parameter int NUM_REQR       = NUM_REQR_DEF,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ID_W           = id_width(NUM_REQR)
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic [NUM_REQR-1:0] reqr_sel,
    input  logic                comp_pready,
    input  logic                comp_pslverr,
    output logic                comp_psel,
    output logic                comp_penable,
    output logic [NUM_REQR-1:0] grant,
    output logic [ID_W-1:0]     grant_id,
    output logic                grant_valid,
    output logic [NUM_REQR-1:0] reqr_pready,
    output logic [NUM_REQR-1:0] reqr_pslverr,
    output logic                timeout_err
);

    // Wait counter wide enough to reach TIMEOUT_CYCLES, saturating
    localparam int          CNT_W   = id_width(TIMEOUT_CYCLES + 1);
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    arb_state_e          state_q, state_d;
    logic [NUM_REQR-1:0] grant_q, grant_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [ID_W-1:0]     last_id_q, last_id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_REQR-1:0] pick_onehot;
    logic [ID_W-1:0]     pick_id;
    logic                pick_valid;
    logic                req_held;
    logic                timeout_hit;

    apb_rr_picker #(
        .N    (NUM_REQR),
        .ID_W (ID_W)
    ) u_picker (
        .req_i         (reqr_sel),
        .last_id_i     (last_id_q),
        .pick_onehot_o (pick_onehot),
        .pick_id_o     (pick_id),
        .pick_valid_o  (pick_valid)
    );

    // The granted requester must keep its select up for the whole transfer
    assign req_held    = reqr_sel[grant_id_q];
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));

    // Completer-side strobes and grant outputs come straight from registers
    assign comp_psel    = (state_q != IDLE);
    assign comp_penable = (state_q == ACCESS);
    assign grant_valid  = (state_q != IDLE);
    assign grant        = grant_q;
    assign grant_id     = grant_id_q;

    // Next-state, grant bookkeeping and response routing
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grant_id_d   = grant_id_q;
        last_id_d    = last_id_q;
        cnt_d        = cnt_q;
        reqr_pready  = '0;
        reqr_pslverr = '0;
        timeout_err  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d    = pick_onehot;
                    grant_id_d = pick_id;
                    state_d    = SETUP;
                end
            end

            SETUP: begin
                cnt_d = '0;
                if (!req_held) begin
                    // Requester withdrew: drop the transfer silently
                    state_d   = IDLE;
                    grant_d   = '0;
                    last_id_d = grant_id_q;
                end else begin
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                if (comp_pready) begin
                    // Normal completion; beats both withdraw and timeout
                    reqr_pready[grant_id_q]  = 1'b1;
                    reqr_pslverr[grant_id_q] = comp_pslverr;
                    state_d   = IDLE;
                    grant_d   = '0;
                    last_id_d = grant_id_q;
                end else if (!req_held) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    last_id_d = grant_id_q;
                end else if (timeout_hit) begin
                    // Hung completer: answer the requester with an error
                    reqr_pready[grant_id_q]  = 1'b1;
                    reqr_pslverr[grant_id_q] = 1'b1;
                    timeout_err = 1'b1;
                    state_d   = IDLE;
                    grant_d   = '0;
                    last_id_d = grant_id_q;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, grant and round-robin pointer registers
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            last_id_q  <= ID_W'(NUM_REQR - 1);
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_apb_completer_arbiter.sv
// Directed bench for apb_completer_arbiter. Two instances share the inputs:
// u_dut uses the default timeout, u_dut_to a short timeout of 4 cycles.
module tb_apb_completer_arbiter;

    logic       clk = 1'b0;
    logic       preset;
    logic [2:0] reqr_sel;
    logic       comp_pready;
    logic       comp_pslverr;

    logic       comp_psel, comp_penable, grant_valid, timeout_err;
    logic [2:0] grant, reqr_pready, reqr_pslverr;
    logic [1:0] grant_id;

    logic       t_comp_psel, t_comp_penable, t_grant_valid, t_timeout_err;
    logic [2:0] t_grant, t_reqr_pready, t_reqr_pslverr;
    logic [1:0] t_grant_id;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    apb_completer_arbiter #(.NUM_REQR(3), .TIMEOUT_CYCLES(256)) u_dut (
        .pclk         (clk),
        .preset       (preset),
        .reqr_sel     (reqr_sel),
        .comp_pready  (comp_pready),
        .comp_pslverr (comp_pslverr),
        .comp_psel    (comp_psel),
        .comp_penable (comp_penable),
        .grant        (grant),
        .grant_id     (grant_id),
        .grant_valid  (grant_valid),
        .reqr_pready  (reqr_pready),
        .reqr_pslverr (reqr_pslverr),
        .timeout_err  (timeout_err)
    );

    apb_completer_arbiter #(.NUM_REQR(3), .TIMEOUT_CYCLES(4)) u_dut_to (
        .pclk         (clk),
        .preset       (preset),
        .reqr_sel     (reqr_sel),
        .comp_pready  (comp_pready),
        .comp_pslverr (comp_pslverr),
        .comp_psel    (t_comp_psel),
        .comp_penable (t_comp_penable),
        .grant        (t_grant),
        .grant_id     (t_grant_id),
        .grant_valid  (t_grant_valid),
        .reqr_pready  (t_reqr_pready),
        .reqr_pslverr (t_reqr_pslverr),
        .timeout_err  (t_timeout_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        preset       = 1'b1;
        reqr_sel     = 3'b000;
        comp_pready  = 1'b0;
        comp_pslverr = 1'b0;
        next_cycle();
        next_cycle();
        preset = 1'b0;
    endtask

    int unsigned exp_order [4] = '{0, 1, 2, 0};
    logic [2:0]  oh;

    initial begin
        // ---------------- reset state ----------------
        preset       = 1'b1;
        reqr_sel     = 3'b111;
        comp_pready  = 1'b1;
        comp_pslverr = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("rst_psel",     comp_psel,    0);
        check_eq("rst_penable",  comp_penable, 0);
        check_eq("rst_grant",    grant,        0);
        check_eq("rst_grant_id", grant_id,     0);
        check_eq("rst_gvalid",   grant_valid,  0);
        check_eq("rst_pready",   reqr_pready,  0);
        check_eq("rst_pslverr",  reqr_pslverr, 0);
        check_eq("rst_timeout",  timeout_err,  0);
        $display("txn reset: outputs idle");

        // ---------------- single request, zero wait ----------------
        do_reset();
        reqr_sel = 3'b001; comp_pready = 1'b1; comp_pslverr = 1'b0;
        @(negedge clk);
        check_eq("single_c0_psel", comp_psel, 0);
        next_cycle();
        @(negedge clk);
        check_eq("single_setup_psel",    comp_psel,    1);
        check_eq("single_setup_penable", comp_penable, 0);
        check_eq("single_setup_grant",   grant,        3'b001);
        check_eq("single_setup_gvalid",  grant_valid,  1);
        check_eq("single_setup_pready",  reqr_pready,  0);
        next_cycle();
        @(negedge clk);
        check_eq("single_acc_penable", comp_penable, 1);
        check_eq("single_acc_pready",  reqr_pready,  3'b001);
        check_eq("single_acc_pslverr", reqr_pslverr, 0);
        next_cycle();
        reqr_sel = 3'b000;
        @(negedge clk);
        check_eq("single_idle_psel",  comp_psel,   0);
        check_eq("single_idle_grant", grant,       0);
        check_eq("single_idle_gid",   grant_id,    0);
        check_eq("single_idle_pready", reqr_pready, 0);
        $display("txn single: req0 completed");

        // ---------------- contention 0,1,2,0 ----------------
        do_reset();
        reqr_sel = 3'b111; comp_pready = 1'b1; comp_pslverr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            oh = 3'b001 << exp_order[i / 3];
            case (i % 3)
                0: begin
                    check_eq($sformatf("cont%0d_idle_gvalid", i), grant_valid, 0);
                    check_eq($sformatf("cont%0d_idle_pready", i), reqr_pready, 0);
                end
                1: begin
                    check_eq($sformatf("cont%0d_setup_grant", i), grant, oh);
                    check_eq($sformatf("cont%0d_setup_gid", i), grant_id, exp_order[i / 3]);
                end
                default: begin
                    check_eq($sformatf("cont%0d_acc_penable", i), comp_penable, 1);
                    check_eq($sformatf("cont%0d_acc_pready", i), reqr_pready, oh);
                end
            endcase
            if (i % 3 == 2) $display("txn contention: req%0d completed", exp_order[i / 3]);
            next_cycle();
        end

        // ---------------- wait states + slave error on req 2 ----------------
        do_reset();
        reqr_sel = 3'b100; comp_pready = 1'b0; comp_pslverr = 1'b0;
        next_cycle();
        @(negedge clk);
        check_eq("wait_setup_grant", grant, 3'b100);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            @(negedge clk);
            check_eq($sformatf("wait%0d_penable", i), comp_penable, 1);
            check_eq($sformatf("wait%0d_pready", i),  reqr_pready,  0);
        end
        next_cycle();
        comp_pready = 1'b1; comp_pslverr = 1'b1;
        @(negedge clk);
        check_eq("wait_done_pready",  reqr_pready,  3'b100);
        check_eq("wait_done_pslverr", reqr_pslverr, 3'b100);
        check_eq("wait_done_timeout", timeout_err,  0);
        next_cycle();
        reqr_sel = 3'b000;
        @(negedge clk);
        check_eq("wait_after_pready", reqr_pready, 0);
        $display("txn wait: req2 error after 5 waits");

        // ---------------- timeout abort (TIMEOUT_CYCLES=4) ----------------
        do_reset();
        reqr_sel = 3'b001; comp_pready = 1'b0; comp_pslverr = 1'b0;
        next_cycle();                       // SETUP
        for (int i = 0; i < 3; i++) begin   // ACCESS cycles 1..3
            next_cycle();
            @(negedge clk);
            check_eq($sformatf("to_wait%0d_terr", i),   t_timeout_err, 0);
            check_eq($sformatf("to_wait%0d_pready", i), t_reqr_pready, 0);
        end
        next_cycle();                       // ACCESS cycle 4
        @(negedge clk);
        check_eq("to_abort_terr",    t_timeout_err,   1);
        check_eq("to_abort_pready",  t_reqr_pready,   3'b001);
        check_eq("to_abort_pslverr", t_reqr_pslverr,  3'b001);
        check_eq("long_no_abort",    reqr_pready,     0);
        next_cycle();
        @(negedge clk);
        check_eq("to_idle_psel", t_comp_psel, 0);
        $display("txn timeout: req0 aborted");
        next_cycle();                       // SETUP again (req0 still asserted)
        for (int i = 0; i < 3; i++) next_cycle();
        next_cycle();                       // 4th ACCESS cycle, pready arrives
        comp_pready = 1'b1;
        @(negedge clk);
        check_eq("to_race_terr",    t_timeout_err,  0);
        check_eq("to_race_pready",  t_reqr_pready,  3'b001);
        check_eq("to_race_pslverr", t_reqr_pslverr, 0);
        $display("txn timeout race: req0 completed normally");

        // ---------------- reset mid-ACCESS ----------------
        do_reset();
        reqr_sel = 3'b010; comp_pready = 1'b1; comp_pslverr = 1'b0;
        next_cycle();                       // SETUP req1
        next_cycle();                       // ACCESS req1 completes, last_id=1
        next_cycle();                       // IDLE
        reqr_sel = 3'b001; comp_pready = 1'b0;
        next_cycle();                       // SETUP req0
        next_cycle();                       // ACCESS wait
        @(negedge clk);
        check_eq("rstmid_pre_gid", grant_id, 0);
        next_cycle();
        preset = 1'b1;
        next_cycle();
        preset = 1'b0; reqr_sel = 3'b110; comp_pready = 1'b1;
        @(negedge clk);
        check_eq("rstmid_psel",    comp_psel,    0);
        check_eq("rstmid_penable", comp_penable, 0);
        check_eq("rstmid_grant",   grant,        0);
        check_eq("rstmid_gvalid",  grant_valid,  0);
        check_eq("rstmid_pready",  reqr_pready,  0);
        next_cycle();
        @(negedge clk);
        check_eq("rstmid_next_gid",   grant_id, 1);
        check_eq("rstmid_next_grant", grant,    3'b010);
        $display("txn reset mid-access: req1 granted first");

        // ---------------- withdraw in SETUP ----------------
        do_reset();
        reqr_sel = 3'b011; comp_pready = 1'b1; comp_pslverr = 1'b0;
        next_cycle();                       // SETUP req0
        reqr_sel = 3'b010;
        @(negedge clk);
        check_eq("wd_setup_grant",  grant,       3'b001);
        check_eq("wd_setup_pready", reqr_pready, 0);
        next_cycle();
        @(negedge clk);
        check_eq("wd_idle_gvalid", grant_valid, 0);
        check_eq("wd_idle_pready", reqr_pready, 0);
        next_cycle();
        @(negedge clk);
        check_eq("wd_next_grant", grant, 3'b010);
        $display("txn withdraw: req0 dropped, req1 granted");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
